parking_gate_controller: RTL and testbench

- Clocked, parametrised successor to the current combinational-edge parking counter.
- Tracks occupancy of two pools, university (uni) and public (pub), whose split depends on the hour of day.
- Runs independent entry and exit gates, each with a valid/ready handshake and a timed gate-open FSM.
- Sits between the gate sensors/badge readers and the occupancy display.

---
 rtl/parking_gate_controller.sv | 129 ++++++++++++
 tb/tb_parking_gate_controller.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_controller.sv
// parking_gate_controller: two-pool parking occupancy tracker with handshaked, timed entry and exit gates
module parking_gate_controller #(
  parameter int CAPACITY    = 700,
  parameter int CNT_W       = 10,
  parameter int PUB_DAY     = 200,
  parameter int PUB_NIGHT   = 500,
  parameter int DAY_START   = 8,
  parameter int RAMP_START  = 13,
  parameter int RAMP_END    = 16,
  parameter int RAMP_STEP   = 50,
  parameter int GATE_CYCLES = 4,
  parameter int DENY_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        hour,
  input  logic              ent_valid,
  input  logic              ent_is_uni,
  output logic              ent_ready,
  output logic              ent_grant,
  output logic              ent_deny,
  input  logic              ext_valid,
  input  logic              ext_is_uni,
  output logic              ext_ready,
  output logic              ext_ack,
  output logic              ext_err,
  output logic              ent_gate_open,
  output logic              ext_gate_open,
  output logic [CNT_W-1:0]  uni_parked,
  output logic [CNT_W-1:0]  pub_parked,
  output logic [CNT_W-1:0]  uni_free,
  output logic [CNT_W-1:0]  pub_free,
  output logic              full,
  output logic [DENY_W-1:0] deny_count
);
  localparam int TMR_W = GATE_CYCLES > 1 ? $clog2(GATE_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, DECIDE, OPEN} state_t;
  state_t ent_st, ext_st;
  logic [TMR_W-1:0] ent_tmr, ext_tmr;
  logic [CNT_W-1:0] pub_alloc, uni_alloc;
  logic [CNT_W:0] total;
  logic [31:0] h;
  logic ent_cls, ext_cls, ent_admit, ext_avail;
  assign h = 32'(hour);
  assign uni_alloc = CNT_W'(CAPACITY) - pub_alloc;
  assign uni_free = uni_alloc > uni_parked ? uni_alloc - uni_parked : '0;
  assign pub_free = pub_alloc > pub_parked ? pub_alloc - pub_parked : '0;
  assign total = {1'b0, uni_parked} + {1'b0, pub_parked};
  assign full = total == (CNT_W+1)'(CAPACITY);
  assign ent_admit = (ent_cls ? uni_free != '0 : pub_free != '0) && total < (CNT_W+1)'(CAPACITY);
  assign ext_avail = ext_cls ? uni_parked != '0 : pub_parked != '0;
  assign ent_grant = ent_st == DECIDE && ent_admit;
  assign ent_deny = ent_st == DECIDE && !ent_admit;
  assign ext_ack = ext_st == DECIDE && ext_avail;
  assign ext_err = ext_st == DECIDE && !ext_avail;
  always_ff @(posedge clk)
    pub_alloc <= rst ? CNT_W'(PUB_NIGHT)
      : (h >= DAY_START && h < RAMP_START) ? CNT_W'(PUB_DAY)
      : (h >= RAMP_START && h < RAMP_END) ? CNT_W'(PUB_DAY + (h - RAMP_START + 1) * RAMP_STEP)
      : CNT_W'(PUB_NIGHT);
  always_ff @(posedge clk)
    if (rst) begin
      uni_parked <= '0;
      pub_parked <= '0;
      deny_count <= '0;
    end else begin
      uni_parked <= uni_parked + CNT_W'(ent_grant && ent_cls) - CNT_W'(ext_ack && ext_cls);
      pub_parked <= pub_parked + CNT_W'(ent_grant && !ent_cls) - CNT_W'(ext_ack && !ext_cls);
      deny_count <= deny_count + DENY_W'(ent_deny && !(&deny_count));
    end
  always_ff @(posedge clk)
    if (rst) begin
      ent_st <= IDLE;
      ent_ready <= 1'b1;
      ent_gate_open <= 1'b0;
      ent_tmr <= '0;
      ent_cls <= 1'b0;
    end else
      case (ent_st)
        IDLE: if (ent_valid) begin
          ent_st <= DECIDE;
          ent_cls <= ent_is_uni;
          ent_ready <= 1'b0;
        end
        DECIDE: if (ent_admit) begin
          ent_st <= OPEN;
          ent_gate_open <= 1'b1;
          ent_tmr <= TMR_W'(GATE_CYCLES - 1);
        end else begin
          ent_st <= IDLE;
          ent_ready <= 1'b1;
        end
        default: if (ent_tmr == '0) begin
          ent_st <= IDLE;
          ent_gate_open <= 1'b0;
          ent_ready <= 1'b1;
        end else
          ent_tmr <= ent_tmr - TMR_W'(1);
      endcase
  always_ff @(posedge clk)
    if (rst) begin
      ext_st <= IDLE;
      ext_ready <= 1'b1;
      ext_gate_open <= 1'b0;
      ext_tmr <= '0;
      ext_cls <= 1'b0;
    end else
      case (ext_st)
        IDLE: if (ext_valid) begin
          ext_st <= DECIDE;
          ext_cls <= ext_is_uni;
          ext_ready <= 1'b0;
        end
        DECIDE: if (ext_avail) begin
          ext_st <= OPEN;
          ext_gate_open <= 1'b1;
          ext_tmr <= TMR_W'(GATE_CYCLES - 1);
        end else begin
          ext_st <= IDLE;
          ext_ready <= 1'b1;
        end
        default: if (ext_tmr == '0) begin
          ext_st <= IDLE;
          ext_gate_open <= 1'b0;
          ext_ready <= 1'b1;
        end else
          ext_tmr <= ext_tmr - TMR_W'(1);
      endcase
endmodule

// File: tb/tb_parking_gate_controller.sv
// tb_parking_gate_controller: directed and random transactions checked against an occupancy model
module tb_parking_gate_controller;
  localparam int CAP = 700;
  localparam int GC = 4;
  logic clk = 1'b0;
  logic rst, ent_valid, ent_is_uni, ext_valid, ext_is_uni;
  logic [4:0] hour;
  logic ent_ready, ent_grant, ent_deny, ext_ready, ext_ack, ext_err;
  logic ent_gate_open, ext_gate_open, full;
  logic [9:0] uni_parked, pub_parked, uni_free, pub_free;
  logic [15:0] deny_count;
  int total_n = 0, bad_n = 0;
  int m_uni = 0, m_pub = 0, m_deny = 0, m_pa = 500;
  parking_gate_controller dut (
    .clk(clk), .rst(rst), .hour(hour),
    .ent_valid(ent_valid), .ent_is_uni(ent_is_uni), .ent_ready(ent_ready),
    .ent_grant(ent_grant), .ent_deny(ent_deny),
    .ext_valid(ext_valid), .ext_is_uni(ext_is_uni), .ext_ready(ext_ready),
    .ext_ack(ext_ack), .ext_err(ext_err),
    .ent_gate_open(ent_gate_open), .ext_gate_open(ext_gate_open),
    .uni_parked(uni_parked), .pub_parked(pub_parked),
    .uni_free(uni_free), .pub_free(pub_free),
    .full(full), .deny_count(deny_count)
  );
  always #5 clk = ~clk;
  function automatic int pa_of(input int hr);
    if (hr >= 8 && hr < 13) return 200;
    if (hr >= 13 && hr < 16) return 200 + (hr - 12) * 50;
    return 500;
  endfunction
  function automatic int pos(input int v);
    return v > 0 ? v : 0;
  endfunction
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total_n++;
    assert (o === e) else begin
      bad_n++;
      $error("FAIL %s got=%0d want=%0d", tag, o, e);
    end
  endtask
  task automatic tick;
    int nxt;
    nxt = rst ? 500 : pa_of(int'(hour));
    @(posedge clk);
    #1;
    m_pa = nxt;
  endtask
  task automatic chk_state(input string t);
    chk({t, ":uni_parked"}, 32'(uni_parked), m_uni);
    chk({t, ":pub_parked"}, 32'(pub_parked), m_pub);
    chk({t, ":uni_free"}, 32'(uni_free), pos(CAP - m_pa - m_uni));
    chk({t, ":pub_free"}, 32'(pub_free), pos(m_pa - m_pub));
    chk({t, ":full"}, 32'(full), 32'(m_uni + m_pub == CAP));
    chk({t, ":deny_count"}, 32'(deny_count), m_deny);
    chk({t, ":ent_ready"}, 32'(ent_ready), 1);
    chk({t, ":ext_ready"}, 32'(ext_ready), 1);
    chk({t, ":ent_gate_open"}, 32'(ent_gate_open), 0);
    chk({t, ":ext_gate_open"}, 32'(ext_gate_open), 0);
  endtask
  task automatic req(input bit e, input bit eu, input bit x, input bit xu, input int hr2, input bit poke);
    bit g, a;
    ent_valid = e;
    ent_is_uni = eu;
    ext_valid = x;
    ext_is_uni = xu;
    tick;
    ent_valid = 1'b0;
    ext_valid = 1'b0;
    if (hr2 >= 0) hour = 5'(hr2);
    g = e && (eu ? CAP - m_pa - m_uni > 0 : m_pa - m_pub > 0) && m_uni + m_pub < CAP;
    a = x && (xu ? m_uni > 0 : m_pub > 0);
    chk("ent_grant", 32'(ent_grant), 32'(g));
    chk("ent_deny", 32'(ent_deny), 32'(e && !g));
    chk("ext_ack", 32'(ext_ack), 32'(a));
    chk("ext_err", 32'(ext_err), 32'(x && !a));
    chk("ent_ready_decide", 32'(ent_ready), 32'(!e));
    chk("ext_ready_decide", 32'(ext_ready), 32'(!x));
    if (g) begin
      if (eu) m_uni++;
      else m_pub++;
    end else if (e && m_deny < 65535) m_deny++;
    if (a) begin
      if (xu) m_uni--;
      else m_pub--;
    end
    tick;
    if (g || a)
      for (int i = 0; i < GC; i++) begin
        chk("ent_gate_open_hold", 32'(ent_gate_open), 32'(g));
        chk("ext_gate_open_hold", 32'(ext_gate_open), 32'(a));
        chk("ent_grant_quiet", 32'(ent_grant), 0);
        if (g) chk("ent_ready_open", 32'(ent_ready), 0);
        if (poke) begin
          ent_valid = (i == 0);
          ent_is_uni = 1'b0;
        end
        tick;
      end
    ent_valid = 1'b0;
    chk_state("req");
  endtask
  initial begin
    #1000000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    int op;
    bit c1, c2;
    rst = 1'b1;
    hour = 5'd0;
    ent_valid = 1'b0;
    ent_is_uni = 1'b0;
    ext_valid = 1'b0;
    ext_is_uni = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    chk("reset_grant", 32'(ent_grant), 0);
    chk("reset_ack", 32'(ext_ack), 0);
    chk_state("reset");
    hour = 5'd10;
    tick;
    tick;
    chk("day_uni_free", 32'(uni_free), 500);
    chk("day_pub_free", 32'(pub_free), 200);
    chk_state("day");
    req(1, 0, 0, 0, -1, 1);
    chk("first_pub_parked", 32'(pub_parked), 1);
    repeat (199) req(1, 0, 0, 0, -1, 0);
    chk("pub_exhausted", 32'(pub_free), 0);
    req(1, 0, 0, 0, 20, 0);
    chk("deny_201", 32'(deny_count), 1);
    chk("pub_held_200", 32'(pub_parked), 200);
    repeat (250) req(1, 0, 0, 0, -1, 0);
    chk("pub_450", 32'(pub_parked), 450);
    hour = 5'd9;
    tick;
    tick;
    chk("pub_free_clamped", 32'(pub_free), 0);
    req(1, 0, 0, 0, -1, 0);
    chk("deny_shrunk", 32'(deny_count), 2);
    repeat (250) req(0, 0, 1, 0, -1, 0);
    chk("pub_free_still_0", 32'(pub_free), 0);
    req(0, 0, 1, 0, -1, 0);
    chk("pub_free_back_1", 32'(pub_free), 1);
    req(0, 0, 1, 1, -1, 0);
    chk("uni_empty_exit", 32'(uni_parked), 0);
    hour = 5'd10;
    tick;
    repeat (5) req(1, 1, 0, 0, -1, 0);
    req(1, 1, 1, 1, -1, 0);
    chk("simultaneous_uni", 32'(uni_parked), 5);
    hour = 5'd20;
    tick;
    repeat (301) req(1, 0, 0, 0, -1, 0);
    repeat (195) req(1, 1, 0, 0, -1, 0);
    chk("lot_full", 32'(full), 1);
    hour = 5'd10;
    tick;
    chk("uni_free_while_full", 32'(uni_free), 300);
    req(1, 1, 0, 0, -1, 0);
    chk("deny_when_full", 32'(deny_count), 3);
    repeat (80) begin
      hour = 5'($urandom_range(0, 31));
      op = int'($urandom_range(0, 3));
      c1 = 1'($urandom);
      c2 = 1'($urandom);
      req(op == 0 || op == 3, c1, op != 0, c2, -1, 0);
    end
    hour = 5'd20;
    tick;
    for (int k = 0; k < 700 && !(m_pub < 500 && m_uni + m_pub < CAP); k++) req(0, 0, 1, 0, -1, 0);
    ent_valid = 1'b1;
    ent_is_uni = 1'b0;
    tick;
    ent_valid = 1'b0;
    chk("pre_rst_grant", 32'(ent_grant), 1);
    tick;
    tick;
    chk("pre_rst_gate", 32'(ent_gate_open), 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    m_uni = 0;
    m_pub = 0;
    m_deny = 0;
    chk("rst_gate_closed", 32'(ent_gate_open), 0);
    chk("rst_ent_ready", 32'(ent_ready), 1);
    chk_state("rst_mid_open");
    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end
endmodule
